// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID operands and EX status in,
// pipeline enables, flushes and stall diagnostics out.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic [1:0]            id_lat_class;
    logic                  modify_pc_ex;
    logic                  div_done;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic [1:0]            stall_cause;
    logic [PERF_W-1:0]     stall_count;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd,
        output id_reg_write, id_lat_class, modify_pc_ex, div_done,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
        input  stall_cause, stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd,
        input  id_reg_write, id_lat_class, modify_pc_ex, div_done,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
        output stall_cause, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Countdown scoreboard for multi-cycle producers plus divider tracking;
// stalls ID until operands are forwardable, EX redirects override stalls.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int MUL_STALL  = 2,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave hz
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_STALL);
    localparam logic [CNT_W-1:0] MUL_L  = CNT_W'(MUL_STALL);

    logic [CNT_W-1:0]      cnt_q [NUM_REGS];
    logic [CNT_W-1:0]      cnt_d [NUM_REGS];
    logic                  div_busy_q, div_busy_d;
    logic [REG_ADDR_W-1:0] div_rd_q, div_rd_d;
    logic [PERF_W-1:0]     stall_count_q, stall_count_d;

    logic use_rs1, use_rs2, rs1_live, rs2_live;
    logic raw_cnt, raw_div, waw_div, struct_div;
    logic stall, issue, wr_en, div_issue;
    logic [CNT_W-1:0] lat;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (hz.id_opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign rs1_live = use_rs1 && (hz.id_rs1 != '0);
    assign rs2_live = use_rs2 && (hz.id_rs2 != '0);

    assign raw_cnt = (rs1_live && (cnt_q[hz.id_rs1] != '0))
                  || (rs2_live && (cnt_q[hz.id_rs2] != '0));
    assign raw_div = div_busy_q
                  && ((rs1_live && (hz.id_rs1 == div_rd_q))
                   || (rs2_live && (hz.id_rs2 == div_rd_q)));
    assign waw_div = div_busy_q && hz.id_reg_write
                  && (hz.id_rd != '0) && (hz.id_rd == div_rd_q);
    assign struct_div = div_busy_q && (hz.id_lat_class == 2'd3);

    assign stall = hz.id_valid
                && (raw_cnt || raw_div || waw_div || struct_div);
    assign issue = hz.id_valid && !stall && !hz.modify_pc_ex;
    assign wr_en = issue && hz.id_reg_write && (hz.id_rd != '0);
    assign div_issue = issue && (hz.id_lat_class == 2'd3)
                    && (hz.id_rd != '0);

    always_comb begin
        hz.pc_en       = 1'b1;
        hz.if_id_en    = 1'b1;
        hz.id_ex_en    = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.stall_cause = 2'd0;
        if (rst) begin
            hz.stall_cause = 2'd0;
        end else if (hz.modify_pc_ex) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (stall) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_en    = 1'b0;
            hz.id_ex_flush = 1'b1;
            if (raw_cnt)
                hz.stall_cause = 2'd1;
            else if (raw_div || waw_div)
                hz.stall_cause = 2'd2;
            else
                hz.stall_cause = 2'd3;
        end
    end

    assign hz.stall_count = stall_count_q;

    always_comb begin
        unique case (hz.id_lat_class)
            2'd1:    lat = LOAD_L;
            2'd2:    lat = MUL_L;
            default: lat = '0;
        endcase
    end

    // A new producer never shortens an older, longer pending countdown.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            if (r != 0 && wr_en && hz.id_rd == REG_ADDR_W'(r)
                && cnt_d[r] < lat)
                cnt_d[r] = lat;
        end
    end

    always_comb begin
        div_busy_d = div_busy_q;
        div_rd_d   = div_rd_q;
        if (div_issue) begin
            div_busy_d = 1'b1;
            div_rd_d   = hz.id_rd;
        end else if (hz.div_done) begin
            div_busy_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !hz.modify_pc_ex && stall_count_q != '1)
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
            div_busy_q    <= 1'b0;
            div_rd_q      <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
            div_busy_q    <= div_busy_d;
            div_rd_q      <= div_rd_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed and random checks of the hazard scoreboard against a
// ready-time reference model.
module tb_hazard_scoreboard_unit;
    localparam int LOAD_STALL = 1;
    localparam int MUL_STALL  = 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(16)) hif ();

    hazard_scoreboard_unit #(
        .NUM_REGS(32), .REG_ADDR_W(5), .LOAD_STALL(LOAD_STALL),
        .MUL_STALL(MUL_STALL), .CNT_W(3), .PERF_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hif.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle from which each register may be consumed.
    int ready_at [32];
    int cyc = 0;
    bit busy_m = 0;
    int drd_m = 0;
    int sc_m = 0;

    function automatic bit reads_rs1(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    endfunction

    function automatic bit reads_rs2(logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit v, logic [6:0] op, int r1, int r2, int rd,
                        bit rw, int cls, bit mpc, bit dd);
        bit u1, u2, rc, rd_hz, st, stl, iss;
        int cause, tgt;
        hif.id_valid     = v;
        hif.id_opcode    = op;
        hif.id_rs1       = 5'(r1);
        hif.id_rs2       = 5'(r2);
        hif.id_rd        = 5'(rd);
        hif.id_reg_write = rw;
        hif.id_lat_class = 2'(cls);
        hif.modify_pc_ex = mpc;
        hif.div_done     = dd;
        #1;
        u1 = reads_rs1(op) && r1 != 0;
        u2 = reads_rs2(op) && r2 != 0;
        rc = (u1 && cyc < ready_at[r1]) || (u2 && cyc < ready_at[r2]);
        rd_hz = busy_m && ((u1 && r1 == drd_m) || (u2 && r2 == drd_m)
                        || (rw && rd != 0 && rd == drd_m));
        st = busy_m && cls == 3;
        stl = v && (rc || rd_hz || st);
        iss = v && !stl && !mpc;
        cause = (rst || mpc || !stl) ? 0 : rc ? 1 : rd_hz ? 2 : 3;
        if (rst) begin
            chk("rst_pc_en", hif.pc_en, 1);
            chk("rst_if_id_en", hif.if_id_en, 1);
            chk("rst_id_ex_en", hif.id_ex_en, 1);
            chk("rst_if_id_flush", hif.if_id_flush, 0);
            chk("rst_id_ex_flush", hif.id_ex_flush, 0);
        end else begin
            chk("pc_en", hif.pc_en, 32'(mpc || !stl));
            chk("if_id_en", hif.if_id_en, 32'(mpc || !stl));
            chk("id_ex_en", hif.id_ex_en, 32'(mpc || !stl));
            chk("if_id_flush", hif.if_id_flush, 32'(mpc));
            chk("id_ex_flush", hif.id_ex_flush, 32'(mpc || stl));
        end
        chk("stall_cause", hif.stall_cause, cause);
        chk("stall_count", hif.stall_count, sc_m);
        @(posedge clk);
        if (rst) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            busy_m = 0;
            drd_m = 0;
            sc_m = 0;
        end else begin
            if (iss && rw && rd != 0 && (cls == 1 || cls == 2)) begin
                tgt = cyc + 1 + (cls == 1 ? LOAD_STALL : MUL_STALL);
                if (tgt > ready_at[rd]) ready_at[rd] = tgt;
            end
            if (iss && cls == 3 && rd != 0) begin
                busy_m = 1;
                drd_m = rd;
            end else if (dd) begin
                busy_m = 0;
            end
            if (stl && !mpc && sc_m < 65535) sc_m++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        step(0, OP_I, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                OP_JALR, OP_LUI, OP_AUIPC, OP_JAL};
        foreach (ready_at[i]) ready_at[i] = 0;
        hif.id_valid = 0;
        hif.id_opcode = OP_I;
        hif.id_rs1 = 0;
        hif.id_rs2 = 0;
        hif.id_rd = 0;
        hif.id_reg_write = 0;
        hif.id_lat_class = 0;
        hif.modify_pc_ex = 0;
        hif.div_done = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        step(1, OP_R, 5, 6, 7, 1, 0, 0, 0);
        rst = 0;
        idle();

        // load-use: exactly one bubble
        step(1, OP_LOAD, 1, 0, 5, 1, 1, 0, 0);
        step(1, OP_R, 5, 1, 6, 1, 0, 0, 0);
        chk("ld_use_pc_en", hif.pc_en, 1);
        step(1, OP_R, 5, 1, 6, 1, 0, 0, 0);
        chk("ld_use_count", hif.stall_count, 1);

        // multiply at distance 0, 1 and 2
        step(1, OP_R, 1, 2, 7, 1, 2, 0, 0);
        repeat (3) step(1, OP_R, 7, 1, 3, 1, 0, 0, 0);
        step(1, OP_R, 1, 2, 7, 1, 2, 0, 0);
        idle();
        repeat (2) step(1, OP_R, 1, 7, 3, 1, 0, 0, 0);
        step(1, OP_R, 1, 2, 7, 1, 2, 0, 0);
        idle();
        idle();
        step(1, OP_STORE, 1, 7, 0, 0, 0, 0, 0);

        // divider RAW, structural, WAW and release
        step(1, OP_R, 1, 2, 8, 1, 3, 0, 0);
        step(1, OP_R, 8, 1, 6, 1, 0, 0, 0);
        chk("div_raw_cause", hif.stall_cause, 2);
        step(1, OP_R, 1, 2, 11, 1, 3, 0, 0);
        chk("div_struct_cause", hif.stall_cause, 3);
        step(1, OP_I, 1, 0, 8, 1, 0, 0, 0);
        step(1, OP_R, 8, 1, 6, 1, 0, 0, 0);
        step(1, OP_R, 8, 1, 6, 1, 0, 0, 1);
        step(1, OP_R, 8, 1, 6, 1, 0, 0, 0);
        chk("div_release_en", hif.id_ex_en, 1);

        // redirect beats a pending load-use stall
        step(1, OP_LOAD, 1, 0, 5, 1, 1, 0, 0);
        step(1, OP_R, 5, 1, 6, 1, 0, 1, 0);
        step(1, OP_R, 5, 1, 6, 1, 0, 0, 0);

        // x0 and unused rs1 never stall
        step(1, OP_LOAD, 1, 0, 0, 1, 1, 0, 0);
        step(1, OP_R, 0, 0, 6, 1, 0, 0, 0);
        step(1, OP_LOAD, 1, 0, 5, 1, 1, 0, 0);
        step(1, OP_LUI, 5, 5, 6, 1, 0, 0, 0);
        idle();

        // mul then load to the same rd
        step(1, OP_R, 1, 2, 9, 1, 2, 0, 0);
        step(1, OP_LOAD, 1, 0, 9, 1, 1, 0, 0);
        repeat (2) step(1, OP_R, 9, 1, 3, 1, 0, 0, 0);

        // reset in the middle of a divide
        step(1, OP_R, 1, 2, 10, 1, 3, 0, 0);
        step(1, OP_LOAD, 1, 0, 12, 1, 2, 0, 0);
        rst = 1;
        step(1, OP_R, 10, 12, 6, 1, 0, 0, 0);
        rst = 0;
        step(1, OP_R, 10, 12, 6, 1, 0, 0, 0);
        chk("post_rst_count", hif.stall_count, 0);
        chk("post_rst_cause", hif.stall_cause, 0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 99) < 85,
                 ops[$urandom_range(0, 8)],
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                 busy_m && $urandom_range(0, 3) == 0);
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use hazard unit.
- Tracks pending register writes from multi-cycle producers (load, pipelined multiplier, iterative divider) in a per-register countdown scoreboard.
- Stalls ID until each source operand is forwardable, and handles divider structural and WAW hazards.
- Sits beside the ID stage; drives PC, IF/ID and ID/EX enables and flushes; gives EX-resolved redirects priority over all stalls.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero and is never tracked.
- REG_ADDR_W, 5, register index width.
- LOAD_STALL, 1, stall cycles a load imposes on an immediate consumer (1..2^CNT_W-1).
- MUL_STALL, 2, stall cycles a multiply imposes on an immediate consumer (1..2^CNT_W-1).
- CNT_W, 3, scoreboard counter width.
- PERF_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  ID opcode; rs1/rs2 usage is decoded internally (R, I, load, store, branch, JALR use rs1; R, store, branch use rs2).
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_lat_class  in  2  producer class: 0 ALU, 1 load, 2 mul, 3 div.
- modify_pc_ex  in  1  redirect resolved in EX.
- div_done  in  1  divider result valid this cycle.
- pc_en, if_id_en, id_ex_en  out  1  stage enables.
- if_id_flush, id_ex_flush  out  1  stage flushes.
- stall_cause  out  2  0 none, 1 RAW on counter, 2 RAW/WAW on divider, 3 divider busy.
- stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[1..NUM_REGS-1] (CNT_W bits each); div_busy; div_rd; stall_count.
- Reset (synchronous): all cnt=0, div_busy=0, div_rd=0, stall_count=0.
- Combinational outputs while rst is high: all enables=1, flushes=0, stall_cause=0.
- issue = id_valid & !stall & !modify_pc_ex.
- raw_cnt: used rsN≠0 and cnt[rsN]≠0.
- raw_div: div_busy and used rsN==div_rd.
- waw_div: div_busy, id_reg_write, and id_rd==div_rd≠0.
- struct_div: div_busy and id_lat_class==3.
- stall = id_valid & (raw_cnt | raw_div | waw_div | struct_div).
- stall_cause priority: 1 (raw_cnt), then 2 (raw_div/waw_div), then 3 (struct_div).
- Output priority:
  - modify_pc_ex: all enables=1, if_id_flush=1, id_ex_flush=1; stall is ignored and stall_cause=0.
  - else stall: pc_en=0, if_id_en=0, id_ex_en=0, id_ex_flush=1 (bubble inserted).
  - else: all enables=1, both flushes=0.
- Counter update, every cycle: each nonzero cnt decrements by 1.
- On issue with id_reg_write and id_rd≠0, cnt[id_rd] loads max(decremented value, L):
  - L=LOAD_STALL for class 1, MUL_STALL for class 2, 0 for class 0.
- On issue of class 3 with id_rd≠0: div_busy=1, div_rd=id_rd next cycle.
- Divider release: div_done clears div_busy at the next edge.
  - Stall persists in the div_done cycle; the consumer proceeds the following cycle.
  - If a div issues in the same cycle as div_done, the new div wins (cannot occur, because struct_div stalls it).
- Flush does not clear scoreboard state; entries belong to older, committed-path instructions.
- Flushed or stalled ID instructions never write the scoreboard.
- Reads of register 0 never stall.
- stall_count increments in every cycle with stall & !modify_pc_ex and saturates at all-ones.

Test Plan:
- Load x5 (class 1) issues; next cycle add x6,x5,x1 in ID -> exactly 1 stall cycle (pc_en=0, id_ex_flush=1, stall_cause=1); issues the cycle after; stall_count=1.
- Mul x7 issues; consumer of x7 immediately in ID -> 2 stall cycles; consumer one cycle later -> 1 stall; two cycles later -> 0.
- Div x8 issues; add using x8 in ID -> stalls (cause 2) through the div_done cycle, issues the next cycle. Second div during busy -> cause 3. Alu writing x8 during busy -> cause 2 (WAW).
- Load x5 in flight with consumer stalled, modify_pc_ex=1 -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cause=0; cnt[5] still decrements normally.
- Load x0, then a consumer of x0 -> no stall. Opcode lui with id_rs1 field=5 and cnt[5]≠0 -> no stall (rs1 unused).
- Mul x9 followed at once by load x9 -> cnt[9]=max(1,1)=1. Assert rst mid-divide -> div_busy=0, all cnt=0, stall_count=0 the next cycle.
